// File: rtl/mmio_port_unit.sv
// Memory-mapped port block: OUT/IN/STATUS/EVCNT registers in a 16-byte window,
// with a two-flop synchronizer and a stability-count debouncer on PortIn.
module mmio_port_unit #(
  parameter logic [31:0] BASE_ADDR       = 32'h1001_0000,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        ChangeIrq
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] SEL_OUT    = 2'd0;
  localparam logic [1:0] SEL_IN     = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_EVCNT  = 2'd3;

  logic [31:0] out_reg;
  logic [7:0]  sync1_reg;
  logic [7:0]  sync2_reg;
  logic [7:0]  cand_reg;
  logic [7:0]  cnt_reg;
  logic [7:0]  in_reg;
  logic        change_reg;
  logic [15:0] evcnt_reg;

  logic [31:0] offset;
  logic [1:0]  sel;
  logic        wr;
  logic        commit;
  logic        change_event;

  // Unsigned subtraction makes addresses below the base wrap to large values,
  // so a single compare covers both window bounds.
  assign offset = Address - BASE_ADDR;
  assign Hit    = (offset < 32'd16);
  assign sel    = offset[3:2];
  assign wr     = MemWrite && Hit;

  assign commit       = (sync2_reg == cand_reg) && (cnt_reg == CNT_LAST);
  assign change_event = commit && (cand_reg != in_reg);

  assign PortOut   = out_reg;
  assign ChangeIrq = change_reg;

  always_comb begin
    ReadData = 32'h0;
    if (MemRead && Hit) begin
      case (sel)
        SEL_OUT:    ReadData = out_reg;
        SEL_IN:     ReadData = {24'h0, in_reg};
        SEL_STATUS: ReadData = {31'h0, change_reg};
        SEL_EVCNT:  ReadData = {16'h0, evcnt_reg};
        default:    ReadData = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg    <= 32'h0;
      sync1_reg  <= 8'h0;
      sync2_reg  <= 8'h0;
      cand_reg   <= 8'h0;
      cnt_reg    <= 8'h0;
      in_reg     <= 8'h0;
      change_reg <= 1'b0;
      evcnt_reg  <= 16'h0;
    end else begin
      sync1_reg <= PortIn;
      sync2_reg <= sync1_reg;

      // Any disagreement restarts the stability count; the count parks at
      // its last value so a stable input keeps re-committing harmlessly.
      if (sync2_reg != cand_reg) begin
        cand_reg <= sync2_reg;
        cnt_reg  <= 8'h0;
      end else if (cnt_reg == CNT_LAST) begin
        in_reg <= cand_reg;
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
      end

      if (wr && sel == SEL_OUT) begin
        out_reg <= WriteData;
      end

      // Hardware set beats software clear so no event is lost.
      if (change_event) begin
        change_reg <= 1'b1;
      end else if (wr && sel == SEL_STATUS && WriteData[0]) begin
        change_reg <= 1'b0;
      end

      if (change_event) begin
        evcnt_reg <= (wr && sel == SEL_EVCNT) ? 16'd1 : evcnt_reg + 16'd1;
      end else if (wr && sel == SEL_EVCNT) begin
        evcnt_reg <= 16'h0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_port_unit.sv
// Directed bench for mmio_port_unit: register access, debounce latency,
// glitch rejection, simultaneous set/clear, counter wrap and reset.
module tb_mmio_port_unit;

  localparam logic [31:0] BASE   = 32'h1001_0000;
  localparam logic [31:0] A_OUT  = BASE + 32'h0;
  localparam logic [31:0] A_IN   = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_EVC  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        ChangeIrq;

  int checks   = 0;
  int failures = 0;

  mmio_port_unit #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .PortIn    (PortIn),
    .PortOut   (PortOut),
    .ChangeIrq (ChangeIrq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance n rising edges, ending just after the following falling edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    Address   = addr;
    WriteData = data;
    tick(1);
    MemWrite  = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    MemRead = 1'b1;
    Address = addr;
    #1;
    check(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  task automatic hit_check(input string tag, input logic [31:0] addr, input logic exp);
    Address = addr;
    #1;
    check(tag, {31'h0, Hit}, {31'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0;
    Address = 32'h0; WriteData = 32'h0; PortIn = 8'h00;
    @(negedge clk);
    tick(2);
    reset = 1'b0;
    tick(8);

    // Idle after reset
    check("rst_portout", PortOut, 32'h0);
    check("rst_irq", {31'h0, ChangeIrq}, 32'h0);
    load_check("rst_out", A_OUT, 32'h0);
    load_check("rst_in", A_IN, 32'h0);
    load_check("rst_stat", A_STAT, 32'h0);
    load_check("rst_evc", A_EVC, 32'h0);

    // Window boundaries
    hit_check("hit_base", BASE, 1'b1);
    hit_check("hit_top", BASE + 32'd15, 1'b1);
    hit_check("hit_above", BASE + 32'd16, 1'b0);
    hit_check("hit_below", BASE - 32'd1, 1'b0);

    // OUT register and out-of-window store
    store(A_OUT, 32'hDEAD_BEEF);
    check("out_port", PortOut, 32'hDEAD_BEEF);
    load_check("out_read", A_OUT, 32'hDEAD_BEEF);
    hit_check("miss_hit", 32'h1002_0000, 1'b0);
    store(32'h1002_0000, 32'h1234_5678);
    check("miss_port", PortOut, 32'hDEAD_BEEF);
    load_check("miss_read", 32'h1002_0000, 32'h0);
    store(A_IN, 32'h0000_00AA);
    load_check("in_ro", A_IN, 32'h0);

    // Debounce latency: stable from e0, commit at e0+6
    PortIn = 8'h5A;
    tick(6);
    load_check("lat_before", A_IN, 32'h0);
    check("lat_irq_before", {31'h0, ChangeIrq}, 32'h0);
    tick(1);
    load_check("lat_commit", A_IN, 32'h5A);
    check("lat_irq", {31'h0, ChangeIrq}, 32'h1);
    load_check("lat_evc", A_EVC, 32'h1);

    // Short glitch never commits
    store(A_STAT, 32'h1);
    check("w1c_clear", {31'h0, ChangeIrq}, 32'h0);
    PortIn = 8'hFF;
    tick(3);
    PortIn = 8'h5A;
    tick(12);
    load_check("glitch_in", A_IN, 32'h5A);
    check("glitch_irq", {31'h0, ChangeIrq}, 32'h0);
    load_check("glitch_evc", A_EVC, 32'h1);

    // Long pulse commits
    PortIn = 8'hFF;
    tick(7);
    load_check("long_in", A_IN, 32'hFF);
    check("long_irq", {31'h0, ChangeIrq}, 32'h1);
    load_check("long_evc", A_EVC, 32'h2);

    // W1C on the same edge as a new event: set wins
    PortIn = 8'h00;
    tick(6);
    store(A_STAT, 32'h1);
    check("simul_irq", {31'h0, ChangeIrq}, 32'h1);
    load_check("simul_in", A_IN, 32'h0);
    load_check("simul_evc", A_EVC, 32'h3);
    store(A_STAT, 32'h1);
    check("w1c_after", {31'h0, ChangeIrq}, 32'h0);
    PortIn = 8'h33;
    tick(7);
    check("ev4_irq", {31'h0, ChangeIrq}, 32'h1);
    store(A_STAT, 32'h0);
    check("w0_noclear", {31'h0, ChangeIrq}, 32'h1);
    load_check("stat_read", A_STAT, 32'h1);
    load_check("ev4_evc", A_EVC, 32'h4);

    // EVCNT clear, clear-with-event, and wrap
    store(A_EVC, 32'hFFFF_FFFF);
    load_check("evc_clear", A_EVC, 32'h0);
    PortIn = 8'h44;
    tick(6);
    store(A_EVC, 32'h0);
    load_check("evc_simul", A_EVC, 32'h1);
    force dut.evcnt_reg = 16'hFFFF;
    tick(1);
    release dut.evcnt_reg;
    tick(1);
    load_check("evc_preload", A_EVC, 32'hFFFF);
    PortIn = 8'h55;
    tick(7);
    load_check("evc_wrap", A_EVC, 32'h0);
    load_check("wrap_in", A_IN, 32'h55);

    // Reset in the middle of a debounce
    PortIn = 8'h66;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("mid_rst_port", PortOut, 32'h0);
    check("mid_rst_irq", {31'h0, ChangeIrq}, 32'h0);
    load_check("mid_rst_in", A_IN, 32'h0);
    reset = 1'b0;
    tick(6);
    load_check("restart_before", A_IN, 32'h0);
    tick(1);
    load_check("restart_commit", A_IN, 32'h66);
    load_check("restart_evc", A_EVC, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
